// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage unit and data memory.
interface mem_access_unit_if #(
  parameter int unsigned XLEN = 32
);
  localparam int unsigned STRB_W = XLEN / 8;

  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [STRB_W-1:0] wstrb;
  logic [XLEN-1:0]   wdata;
  logic              ack;
  logic [XLEN-1:0]   rdata;

  // Load/store unit side: issues requests, receives completion and read data
  modport master (
    output req, we, addr, wstrb, wdata,
    input  ack, rdata
  );

  // Memory side
  modport slave (
    input  req, we, addr, wstrb, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues data-memory requests, stalls the pipeline
// while a request is outstanding, and aligns/extends load data for MEM/WB.
module mem_access_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  input  logic [31:0]           ex_alu_out,
  input  logic [31:0]           ex_rs2_data,
  mem_access_unit_if.master     dm,
  output logic                  mem_stall,
  output logic                  mem_fault,
  output logic [31:0]           wb_alu_out,
  output logic [31:0]           wb_ld_data
);

  localparam int unsigned STRB_W = XLEN / 8;

  localparam logic [2:0] FN_LB  = 3'd0;
  localparam logic [2:0] FN_LH  = 3'd1;
  localparam logic [2:0] FN_LW  = 3'd2;
  localparam logic [2:0] FN_LBU = 3'd4;
  localparam logic [2:0] FN_LHU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       ld_buf_q, ld_buf_d;
  logic              fault_q, fault_d;

  logic              op_c;
  logic              legal_c;
  logic [STRB_W-1:0] st_wstrb_c;
  logic [31:0]       st_wdata_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;
  logic [31:0]       ld_ext_c;

  // Decode the EX/MEM slot: is there a memory op, and is it size/alignment legal
  always_comb begin
    op_c    = ex_valid & (ex_mem_read | ex_mem_write);
    legal_c = 1'b0;
    case (ex_funct3)
      FN_LB:   legal_c = 1'b1;
      FN_LH:   legal_c = ~ex_alu_out[0];
      FN_LW:   legal_c = (ex_alu_out[1:0] == 2'b00);
      FN_LBU:  legal_c = ~ex_mem_write;
      FN_LHU:  legal_c = ~ex_mem_write & ~ex_alu_out[0];
      default: legal_c = 1'b0;
    endcase
  end

  // Store byte strobes and lane-replicated write data; loads carry none
  always_comb begin
    st_wstrb_c = '0;
    st_wdata_c = '0;
    if (ex_mem_write) begin
      case (ex_funct3)
        FN_LB: begin
          st_wstrb_c = 4'b0001 << ex_alu_out[1:0];
          st_wdata_c = {4{ex_rs2_data[7:0]}};
        end
        FN_LH: begin
          st_wstrb_c = 4'b0011 << {ex_alu_out[1], 1'b0};
          st_wdata_c = {2{ex_rs2_data[15:0]}};
        end
        FN_LW: begin
          st_wstrb_c = 4'b1111;
          st_wdata_c = ex_rs2_data;
        end
        default: begin
          st_wstrb_c = '0;
          st_wdata_c = '0;
        end
      endcase
    end
  end

  // Select the addressed lane of the returned word and sign/zero-extend it
  always_comb begin
    ld_byte_c = 8'h00;
    case (lane_q)
      2'd0: ld_byte_c = dm.rdata[7:0];
      2'd1: ld_byte_c = dm.rdata[15:8];
      2'd2: ld_byte_c = dm.rdata[23:16];
      2'd3: ld_byte_c = dm.rdata[31:24];
      default: ld_byte_c = 8'h00;
    endcase
    ld_half_c = lane_q[1] ? dm.rdata[31:16] : dm.rdata[15:0];
    ld_ext_c  = '0;
    if (!we_q) begin
      case (funct3_q)
        FN_LB:   ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
        FN_LH:   ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
        FN_LW:   ld_ext_c = dm.rdata;
        FN_LBU:  ld_ext_c = {24'h000000, ld_byte_c};
        FN_LHU:  ld_ext_c = {16'h0000, ld_half_c};
        default: ld_ext_c = '0;
      endcase
    end
  end

  // Request FSM next-state, registered-output next values and stall/writeback outputs
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    funct3_d   = funct3_q;
    lane_d     = lane_q;
    ld_buf_d   = ld_buf_q;
    fault_d    = 1'b0;
    mem_stall  = 1'b0;
    wb_ld_data = '0;
    case (state_q)
      ST_IDLE: begin
        if (rst && op_c) begin
          if (legal_c) begin
            mem_stall = 1'b1;
            addr_d    = {ex_alu_out[31:2], 2'b00};
            we_d      = ex_mem_write;
            wstrb_d   = st_wstrb_c;
            wdata_d   = st_wdata_c;
            funct3_d  = ex_funct3;
            lane_d    = ex_alu_out[1:0];
            req_d     = 1'b1;
            state_d   = ST_WAIT;
          end else begin
            fault_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        mem_stall = 1'b1;
        if (dm.ack) begin
          req_d    = 1'b0;
          ld_buf_d = ld_ext_c;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        wb_ld_data = ld_buf_q;
        state_d    = ST_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset drops any outstanding request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      lane_q   <= '0;
      ld_buf_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      funct3_q <= funct3_d;
      lane_q   <= lane_d;
      ld_buf_q <= ld_buf_d;
      fault_q  <= fault_d;
    end
  end

  assign dm.req     = req_q;
  assign dm.we      = we_q;
  assign dm.addr    = addr_q;
  assign dm.wstrb   = wstrb_q;
  assign dm.wdata   = wdata_q;
  assign mem_fault  = fault_q;
  assign wb_alu_out = ex_alu_out;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_out;
  logic [31:0] ex_rs2_data;
  logic        mem_stall;
  logic        mem_fault;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_ld_data;

  int checks;
  int errors;

  mem_access_unit_if dmif ();

  mem_access_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_mem_read),
    .ex_mem_write (ex_mem_write),
    .ex_funct3    (ex_funct3),
    .ex_alu_out   (ex_alu_out),
    .ex_rs2_data  (ex_rs2_data),
    .dm           (dmif),
    .mem_stall    (mem_stall),
    .mem_fault    (mem_fault),
    .wb_alu_out   (wb_alu_out),
    .wb_ld_data   (wb_ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    ex_funct3    = 3'd0;
    ex_alu_out   = 32'h0;
    ex_rs2_data  = 32'h0;
    dmif.ack     = 1'b0;
    dmif.rdata   = 32'h0;
  endtask

  // Drive one memory op; ack is raised d cycles after dm_req is first expected high.
  // Returns what the DUT showed on the bus and at writeback.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int d,
                        output int stall_cnt, output logic req1, output logic we1,
                        output logic [31:0] addr1, output logic [3:0] strb1,
                        output logic [31:0] wdata1, output logic [31:0] ld,
                        output logic [31:0] alu_wb, output logic req_done,
                        output logic req_after);
    stall_cnt    = 0;
    ex_valid     = 1'b1;
    ex_mem_read  = rd;
    ex_mem_write = wr;
    ex_funct3    = f3;
    ex_alu_out   = addr;
    ex_rs2_data  = rs2;
    #1;
    if (mem_stall) stall_cnt++;
    cyc();
    req1   = dmif.req;
    we1    = dmif.we;
    addr1  = dmif.addr;
    strb1  = dmif.wstrb;
    wdata1 = dmif.wdata;
    for (int n = 0; n <= d; n++) begin
      if (mem_stall) stall_cnt++;
      if (n == d) begin
        dmif.ack   = 1'b1;
        dmif.rdata = rdata;
      end
      cyc();
    end
    dmif.ack   = 1'b0;
    dmif.rdata = 32'h0;
    #1;
    if (mem_stall) stall_cnt++;
    ld       = wb_ld_data;
    alu_wb   = wb_alu_out;
    req_done = dmif.req;
    ex_valid     = 1'b0;
    ex_mem_read  = 1'b0;
    ex_mem_write = 1'b0;
    cyc();
    req_after = dmif.req;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ex_valid     = 1'($urandom);
      ex_mem_read  = 1'($urandom);
      ex_mem_write = 1'($urandom);
      ex_funct3    = 3'($urandom);
      ex_alu_out   = $urandom;
      ex_rs2_data  = $urandom;
      dmif.ack     = 1'($urandom);
      dmif.rdata   = $urandom;
      cyc();
      checks++;
      if ({dmif.req, dmif.we, dmif.wstrb, mem_fault, mem_stall} !== 8'h00 ||
          dmif.addr !== 32'h0 || dmif.wdata !== 32'h0 || wb_ld_data !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs: got req=%b we=%b addr=%h wstrb=%b wdata=%h fault=%b stall=%b ld=%h, expected all 0",
                 dmif.req, dmif.we, dmif.addr, dmif.wstrb, dmif.wdata, mem_fault, mem_stall, wb_ld_data);
      end
    end
    idle_inputs();
    rst = 1'b1;
    cyc();
    checks++;
    if (mem_stall !== 1'b0 || dmif.req !== 1'b0 || wb_ld_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_release_idle: got stall=%b req=%b ld=%h, expected 0/0/0", mem_stall, dmif.req, wb_ld_data);
    end
  endtask

  task automatic test_lw();
    int sc; logic r1, w1, rdn, raf; logic [31:0] a1, wd1, ld, alu; logic [3:0] s1;
    run_op(1'b1, 1'b0, 3'd2, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 2,
           sc, r1, w1, a1, s1, wd1, ld, alu, rdn, raf);
    checks++;
    if (r1 !== 1'b1 || w1 !== 1'b0 || a1 !== 32'h0000_1004 || s1 !== 4'b0000 || wd1 !== 32'h0) begin
      errors++;
      $display("FAIL lw_request: got req=%b we=%b addr=%h wstrb=%b wdata=%h, expected 1/0/00001004/0000/0", r1, w1, a1, s1, wd1);
    end
    checks++;
    if (sc !== 4) begin
      errors++;
      $display("FAIL lw_stall_cycles: got %0d expected 4", sc);
    end
    checks++;
    if (ld !== 32'hDEAD_BEEF || alu !== 32'h0000_1004) begin
      errors++;
      $display("FAIL lw_writeback: got ld=%h alu=%h expected deadbeef/00001004", ld, alu);
    end
    checks++;
    if (rdn !== 1'b0 || raf !== 1'b0) begin
      errors++;
      $display("FAIL lw_req_drop: got done=%b after=%b expected 0/0", rdn, raf);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3 [4]  = '{3'd0, 3'd4, 3'd5, 3'd1};
    logic [31:0] ad [4]  = '{32'h1003, 32'h1003, 32'h1002, 32'h1002};
    logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF, 32'hFFFF_80FF};
    int sc; logic r1, w1, rdn, raf; logic [31:0] a1, wd1, ld, alu; logic [3:0] s1;
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 1'b0, f3[i], ad[i], 32'h0, 32'h80FF_1234, 1,
             sc, r1, w1, a1, s1, wd1, ld, alu, rdn, raf);
      checks++;
      if (ld !== exp[i] || a1 !== 32'h0000_1000 || sc !== 3) begin
        errors++;
        $display("FAIL load_extend_%0d: got ld=%h addr=%h stall=%0d expected %h/00001000/3", i, ld, a1, sc, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    int sc; logic r1, w1, rdn, raf; logic [31:0] a1, wd1, ld, alu; logic [3:0] s1;
    run_op(1'b0, 1'b1, 3'd1, 32'h0000_2002, 32'h0000_ABCD, 32'h1111_1111, 0,
           sc, r1, w1, a1, s1, wd1, ld, alu, rdn, raf);
    checks++;
    if (r1 !== 1'b1 || w1 !== 1'b1 || a1 !== 32'h0000_2000 || s1 !== 4'b1100 || wd1 !== 32'hABCD_ABCD) begin
      errors++;
      $display("FAIL sh_request: got req=%b we=%b addr=%h wstrb=%b wdata=%h, expected 1/1/00002000/1100/abcdabcd", r1, w1, a1, s1, wd1);
    end
    checks++;
    if (ld !== 32'h0 || sc !== 2 || raf !== 1'b0) begin
      errors++;
      $display("FAIL sh_complete: got ld=%h stall=%0d req_after=%b expected 0/2/0", ld, sc, raf);
    end
    run_op(1'b1, 1'b1, 3'd0, 32'h0000_2001, 32'h1234_5678, 32'h0, 1,
           sc, r1, w1, a1, s1, wd1, ld, alu, rdn, raf);
    checks++;
    if (w1 !== 1'b1 || s1 !== 4'b0010 || wd1 !== 32'h7878_7878 || ld !== 32'h0) begin
      errors++;
      $display("FAIL sb_request: got we=%b wstrb=%b wdata=%h ld=%h, expected 1/0010/78787878/0", w1, s1, wd1, ld);
    end
  endtask

  task automatic test_fault();
    logic [2:0]  f3 [3] = '{3'd2, 3'd3, 3'd4};
    logic        wr [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] ad [3] = '{32'h1002, 32'h1000, 32'h1000};
    for (int i = 0; i < 3; i++) begin
      ex_valid     = 1'b1;
      ex_mem_read  = ~wr[i];
      ex_mem_write = wr[i];
      ex_funct3    = f3[i];
      ex_alu_out   = ad[i];
      #1;
      checks++;
      if (mem_stall !== 1'b0 || mem_fault !== 1'b0) begin
        errors++;
        $display("FAIL fault_issue_%0d: got stall=%b fault=%b expected 0/0", i, mem_stall, mem_fault);
      end
      cyc();
      idle_inputs();
      #1;
      checks++;
      if (mem_fault !== 1'b1 || dmif.req !== 1'b0 || wb_ld_data !== 32'h0) begin
        errors++;
        $display("FAIL fault_pulse_%0d: got fault=%b req=%b ld=%h expected 1/0/0", i, mem_fault, dmif.req, wb_ld_data);
      end
      cyc();
      checks++;
      if (mem_fault !== 1'b0 || dmif.req !== 1'b0 || mem_stall !== 1'b0) begin
        errors++;
        $display("FAIL fault_end_%0d: got fault=%b req=%b stall=%b expected 0/0/0", i, mem_fault, dmif.req, mem_stall);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    int sc; logic r1, w1, rdn, raf; logic [31:0] a1, wd1, ld, alu; logic [3:0] s1;
    ex_valid    = 1'b1;
    ex_mem_read = 1'b1;
    ex_funct3   = 3'd2;
    ex_alu_out  = 32'h0000_1008;
    cyc();
    checks++;
    if (dmif.req !== 1'b1 || mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_entry: got req=%b stall=%b expected 1/1", dmif.req, mem_stall);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dmif.req !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_req_drop: got req=%b expected 0", dmif.req);
    end
    idle_inputs();
    cyc();
    rst = 1'b1;
    dmif.ack   = 1'b1;
    dmif.rdata = 32'h5555_AAAA;
    cyc();
    dmif.ack = 1'b0;
    #1;
    checks++;
    if (dmif.req !== 1'b0 || mem_stall !== 1'b0 || wb_ld_data !== 32'h0) begin
      errors++;
      $display("FAIL rst_stray_ack: got req=%b stall=%b ld=%h expected 0/0/0", dmif.req, mem_stall, wb_ld_data);
    end
    run_op(1'b0, 1'b1, 3'd2, 32'h0000_3008, 32'hCAFE_F00D, 32'h0, 1,
           sc, r1, w1, a1, s1, wd1, ld, alu, rdn, raf);
    checks++;
    if (r1 !== 1'b1 || w1 !== 1'b1 || s1 !== 4'b1111 || wd1 !== 32'hCAFE_F00D || a1 !== 32'h0000_3008 || sc !== 3) begin
      errors++;
      $display("FAIL rst_then_sw: got req=%b we=%b wstrb=%b wdata=%h addr=%h stall=%0d expected 1/1/1111/cafef00d/00003008/3",
               r1, w1, s1, wd1, a1, sc);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_lw();
    test_load_extend();
    test_store();
    test_fault();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
